// File: rtl/sa_axi_pkg.sv
// Shared types and constants for the S00_AXI burst responder.
//   burst_t   : AXI burst encodings
//   RESP_*    : AXI response codes used by this slave
//   wstate_t  : write-path FSM states
//   rstate_t  : read-path FSM states
//   burst_err : flags bursts this slave refuses to service
package sa_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Wider-than-bus beats, the reserved burst code and WRAP lengths other
    // than 2/4/8/16 beats are all answered with SLVERR.
    function automatic logic burst_err(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/sa_axi_burst_addr_gen.sv
// Combinational next-beat address generator for one AXI burst.
//   addr      in  : address of the current beat
//   len       in  : AxLEN (beats - 1)
//   size      in  : AxSIZE (bytes per beat = 1 << size)
//   burst     in  : AxBURST
//   next_addr out : address of the following beat
//   err       out : burst cannot be serviced (SLVERR)
module sa_axi_burst_addr_gen
    import sa_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);

    logic [ADDR_WIDTH-1:0] bytes_s;
    logic [ADDR_WIDTH-1:0] incr_s;
    logic [ADDR_WIDTH-1:0] mask_s;
    logic [11:0]           wrap_bytes_s;
    burst_t                burst_s;

    // Next address per burst type; INCR overflow wraps modulo the memory size.
    always_comb begin
        burst_s      = burst_t'(burst);
        bytes_s      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        incr_s       = addr + bytes_s;
        // WRAP window is (len+1)*bytes; only the offset bits inside it advance.
        wrap_bytes_s = ({4'b0000, len} + 12'd1) << size;
        mask_s       = ADDR_WIDTH'(wrap_bytes_s - 12'd1);
        err          = burst_err(len, size, burst);
        case (burst_s)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_s;
            BURST_WRAP:  next_addr = (addr & ~mask_s) | (incr_s & mask_s);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/sa_axi4_burst_slave.sv
// AXI4 burst slave backing S00_AXI with an on-chip word memory.
// Independent write (AW/W/B) and read (AR/R) paths, one outstanding burst
// each, one data beat per cycle per direction.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   AW*, W*, B*                : write address, data and response channels
//   AR*, R*                    : read address and data channels
//   *LOCK/*CACHE/*PROT/*QOS/*REGION/*USER inputs are ignored; BUSER/RUSER are 0
module sa_axi4_burst_slave
    import sa_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic                            S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WUSER,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic                            S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int AW         = C_S_AXI_ADDR_WIDTH;
    localparam int DW         = C_S_AXI_DATA_WIDTH;
    localparam int STRB_WIDTH = DW / 8;
    localparam int DEPTH      = 2 ** (AW - 2);

    logic [DW-1:0] mem_r [DEPTH];

    // Write path state
    wstate_t                     wstate_r;
    logic                        awready_r, wready_r, bvalid_r, wlast_err_r;
    logic [1:0]                  bresp_r;
    logic [C_S_AXI_ID_WIDTH-1:0] bid_r;
    logic [AW-1:0]               waddr_r, wnext_s;
    logic [7:0]                  wlen_r, wcnt_r;
    logic [2:0]                  wsize_r;
    logic [1:0]                  wburst_r;
    logic                        werr_s, we_s;

    // Read path state
    rstate_t                     rstate_r;
    logic                        arready_r, rvalid_r, rlast_r;
    logic [1:0]                  rresp_r;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_r;
    logic [DW-1:0]               rdata_r;
    logic [AW-1:0]               raddr_r, rnext_s, rd_addr_s;
    logic [7:0]                  rlen_r, rcnt_r;
    logic [2:0]                  rsize_r;
    logic [1:0]                  rburst_r;
    logic                        rerr_s, rd_en_s, rd_zero_s;

    logic                        unused_inputs_s;

    assign unused_inputs_s = &{1'b0, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                               S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER, S_AXI_ARLOCK,
                               S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                               S_AXI_ARUSER};

    sa_axi_burst_addr_gen #(.ADDR_WIDTH(AW)) u_wr_addr_gen (
        .addr(waddr_r), .len(wlen_r), .size(wsize_r), .burst(wburst_r),
        .next_addr(wnext_s), .err(werr_s)
    );

    sa_axi_burst_addr_gen #(.ADDR_WIDTH(AW)) u_rd_addr_gen (
        .addr(raddr_r), .len(rlen_r), .size(rsize_r), .burst(rburst_r),
        .next_addr(rnext_s), .err(rerr_s)
    );

    // Memory write enable: accepted W beat of a serviceable burst.
    always_comb begin
        we_s = 1'b0;
        if ((wstate_r == W_DATA) && wready_r && S_AXI_WVALID && !werr_s) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Read port: the AR handshake fetches beat 0, each non-last R handshake fetches the next beat.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = rnext_s;
        rd_zero_s = rerr_s;
        if (rstate_r == R_IDLE) begin
            rd_en_s   = arready_r && S_AXI_ARVALID;
            rd_addr_s = S_AXI_ARADDR;
            rd_zero_s = burst_err(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
        end else begin
            rd_en_s   = S_AXI_RREADY && !rlast_r;
            rd_addr_s = rnext_s;
            rd_zero_s = rerr_s;
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (we_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_r[waddr_r[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Registered read data; a write to the same word in the same cycle is not seen.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata_r <= '0;
        end else if (rd_en_s) begin
            rdata_r <= rd_zero_s ? {DW{1'b0}} : mem_r[rd_addr_s[AW-1:2]];
        end
    end

    // Write FSM: address latch, data beats, response hold.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_r    <= W_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            bid_r       <= '0;
            waddr_r     <= '0;
            wlen_r      <= 8'd0;
            wcnt_r      <= 8'd0;
            wsize_r     <= 3'd0;
            wburst_r    <= 2'b00;
            wlast_err_r <= 1'b0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (awready_r && S_AXI_AWVALID) begin
                        bid_r       <= S_AXI_AWID;
                        waddr_r     <= S_AXI_AWADDR;
                        wlen_r      <= S_AXI_AWLEN;
                        wsize_r     <= S_AXI_AWSIZE;
                        wburst_r    <= S_AXI_AWBURST;
                        wcnt_r      <= 8'd0;
                        wlast_err_r <= 1'b0;
                        awready_r   <= 1'b0;
                        wready_r    <= 1'b1;
                        wstate_r    <= W_DATA;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wready_r && S_AXI_WVALID) begin
                        waddr_r <= wnext_s;
                        wcnt_r  <= wcnt_r + 8'd1;
                        // The beat count, not WLAST, ends the burst; WLAST disagreement only taints BRESP.
                        if (wcnt_r == wlen_r) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bresp_r  <= (werr_s || wlast_err_r || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                            wstate_r <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            wlast_err_r <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wstate_r  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_r  <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: address latch, then one beat per RREADY cycle with RLAST on beat len.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rid_r     <= '0;
            raddr_r   <= '0;
            rlen_r    <= 8'd0;
            rcnt_r    <= 8'd0;
            rsize_r   <= 3'd0;
            rburst_r  <= 2'b00;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (arready_r && S_AXI_ARVALID) begin
                        rid_r     <= S_AXI_ARID;
                        raddr_r   <= S_AXI_ARADDR;
                        rlen_r    <= S_AXI_ARLEN;
                        rsize_r   <= S_AXI_ARSIZE;
                        rburst_r  <= S_AXI_ARBURST;
                        rcnt_r    <= 8'd0;
                        rresp_r   <= burst_err(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST) ?
                                     RESP_SLVERR : RESP_OKAY;
                        rlast_r   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        rstate_r  <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            rstate_r  <= R_IDLE;
                        end else begin
                            raddr_r <= rnext_s;
                            rcnt_r  <= rcnt_r + 8'd1;
                            rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
                        end
                    end
                end
                default: begin
                    rstate_r  <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_BID     = bid_r;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RUSER   = 1'b0;

endmodule
